// File: rtl/peridot_uart_rxd.sv
// peridot_uart_rxd: 8N1 serial receiver with mid-bit sampling feeding a small
// show-ahead FIFO that drives an Avalon-ST source. Framing errors and FIFO
// overruns are reported as single-cycle pulses.
module peridot_uart_rxd #(
   parameter int CLOCK_FREQUENCY = 50000000,
   parameter int UART_BAUDRATE   = 115200,
   parameter int FIFO_DEPTH_BITS = 2
) (
   input  logic       clock_sig,
   input  logic       reset_sig,
   input  logic       rxd,
   input  logic       out_ready,
   output logic       out_valid,
   output logic [7:0] out_data,
   output logic       framing_error,
   output logic       overrun
);

   localparam int BIT_CYCLES  = CLOCK_FREQUENCY / UART_BAUDRATE;
   localparam int HALF_CYCLES = BIT_CYCLES / 2;
   localparam int TW          = $clog2(BIT_CYCLES);
   localparam int PW          = FIFO_DEPTH_BITS + 1;
   localparam int DEPTH       = 1 << FIFO_DEPTH_BITS;

   localparam logic [TW-1:0] BIT_RELOAD  = TW'(BIT_CYCLES - 1);
   localparam logic [TW-1:0] HALF_RELOAD = TW'(HALF_CYCLES - 1);
   localparam logic [TW-1:0] TIMER_ZERO  = {TW{1'b0}};
   localparam logic [PW-1:0] PTR_ONE     = PW'(1);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_START = 3'd1,
      ST_DATA  = 3'd2,
      ST_STOP  = 3'd3,
      ST_BREAK = 3'd4
   } state_t;

   // Full when the wrap bits differ and the index bits match.
   function automatic logic fifo_full(input logic [PW-1:0] wr, input logic [PW-1:0] rd);
      return (wr[PW-1] != rd[PW-1]) && (wr[PW-2:0] == rd[PW-2:0]);
   endfunction

   // synchroniser and edge detector
   logic sync1_r, sync2_r, prev_r;
   logic rx_s, fall_s;

   // receiver state
   state_t        state_r, state_nxt_s;
   logic [TW-1:0] timer_r, timer_nxt_s;
   logic [7:0]    shift_r, shift_nxt_s;
   logic [2:0]    bit_idx_r, bit_idx_nxt_s;
   logic          expiry_s, push_req_s, frame_err_s;

   // FIFO state
   logic [7:0]    mem_r [DEPTH];
   logic [PW-1:0] wr_ptr_r, rd_ptr_r, wr_ptr_nxt_s, rd_ptr_nxt_s;
   logic          full_s, pop_s, push_ok_s, overrun_s, empty_nxt_s;
   logic [7:0]    head_nxt_s;

   // registered outputs
   logic          out_valid_r, framing_error_r, overrun_r;
   logic [7:0]    out_data_r;

   assign rx_s   = sync2_r;
   assign fall_s = prev_r && !rx_s;

   // Two-flop synchroniser plus previous-value register; idle-high reset values.
   always_ff @(posedge clock_sig or posedge reset_sig) begin
      if (reset_sig) begin
         sync1_r <= 1'b1;
         sync2_r <= 1'b1;
         prev_r  <= 1'b1;
      end else begin
         sync1_r <= rxd;
         sync2_r <= sync1_r;
         prev_r  <= sync2_r;
      end
   end

   // Receiver next-state: mid-bit timing, start-glitch rejection, stop check.
   always_comb begin
      state_nxt_s   = state_r;
      timer_nxt_s   = timer_r;
      shift_nxt_s   = shift_r;
      bit_idx_nxt_s = bit_idx_r;
      push_req_s    = 1'b0;
      frame_err_s   = 1'b0;
      expiry_s      = (timer_r == TIMER_ZERO);
      case (state_r)
         ST_IDLE: begin
            if (fall_s) begin
               timer_nxt_s = HALF_RELOAD;
               state_nxt_s = ST_START;
            end else begin
               timer_nxt_s = timer_r;
            end
         end
         ST_START: begin
            if (expiry_s) begin
               if (rx_s) begin
                  state_nxt_s = ST_IDLE;
               end else begin
                  timer_nxt_s   = BIT_RELOAD;
                  bit_idx_nxt_s = 3'd0;
                  state_nxt_s   = ST_DATA;
               end
            end else begin
               timer_nxt_s = timer_r - 1'b1;
            end
         end
         ST_DATA: begin
            if (expiry_s) begin
               shift_nxt_s = {rx_s, shift_r[7:1]};
               timer_nxt_s = BIT_RELOAD;
               if (bit_idx_r == 3'd7) begin
                  state_nxt_s = ST_STOP;
               end else begin
                  bit_idx_nxt_s = bit_idx_r + 3'd1;
               end
            end else begin
               timer_nxt_s = timer_r - 1'b1;
            end
         end
         ST_STOP: begin
            if (expiry_s) begin
               timer_nxt_s = TIMER_ZERO;
               if (rx_s) begin
                  push_req_s  = 1'b1;
                  state_nxt_s = ST_IDLE;
               end else begin
                  frame_err_s = 1'b1;
                  state_nxt_s = ST_BREAK;
               end
            end else begin
               timer_nxt_s = timer_r - 1'b1;
            end
         end
         ST_BREAK: begin
            // A held-low line must return high before a new start can begin.
            if (rx_s) begin
               state_nxt_s = ST_IDLE;
            end else begin
               state_nxt_s = ST_BREAK;
            end
         end
         default: begin
            state_nxt_s = ST_IDLE;
            timer_nxt_s = TIMER_ZERO;
         end
      endcase
   end

   // Receiver state registers.
   always_ff @(posedge clock_sig or posedge reset_sig) begin
      if (reset_sig) begin
         state_r   <= ST_IDLE;
         timer_r   <= TIMER_ZERO;
         shift_r   <= 8'h00;
         bit_idx_r <= 3'd0;
      end else begin
         state_r   <= state_nxt_s;
         timer_r   <= timer_nxt_s;
         shift_r   <= shift_nxt_s;
         bit_idx_r <= bit_idx_nxt_s;
      end
   end

   // FIFO control: a pop in the same cycle frees the slot for a push at full.
   always_comb begin
      full_s       = fifo_full(wr_ptr_r, rd_ptr_r);
      pop_s        = out_valid_r && out_ready;
      push_ok_s    = push_req_s && (!full_s || pop_s);
      overrun_s    = push_req_s && !push_ok_s;
      wr_ptr_nxt_s = wr_ptr_r;
      rd_ptr_nxt_s = rd_ptr_r;
      if (push_ok_s) begin
         wr_ptr_nxt_s = wr_ptr_r + PTR_ONE;
      end else begin
         wr_ptr_nxt_s = wr_ptr_r;
      end
      if (pop_s) begin
         rd_ptr_nxt_s = rd_ptr_r + PTR_ONE;
      end else begin
         rd_ptr_nxt_s = rd_ptr_r;
      end
      empty_nxt_s = (wr_ptr_nxt_s == rd_ptr_nxt_s);
      // The head register mirrors mem[rd_ptr]; bypass the byte being written there.
      if (empty_nxt_s) begin
         head_nxt_s = 8'h00;
      end else if (push_ok_s && (wr_ptr_r[PW-2:0] == rd_ptr_nxt_s[PW-2:0])) begin
         head_nxt_s = shift_r;
      end else begin
         head_nxt_s = mem_r[rd_ptr_nxt_s[PW-2:0]];
      end
   end

   // FIFO storage; contents need no reset since the head register masks them.
   always_ff @(posedge clock_sig) begin
      if (push_ok_s) begin
         mem_r[wr_ptr_r[PW-2:0]] <= shift_r;
      end
   end

   // FIFO pointers, registered stream outputs and error pulses.
   always_ff @(posedge clock_sig or posedge reset_sig) begin
      if (reset_sig) begin
         wr_ptr_r        <= {PW{1'b0}};
         rd_ptr_r        <= {PW{1'b0}};
         out_valid_r     <= 1'b0;
         out_data_r      <= 8'h00;
         framing_error_r <= 1'b0;
         overrun_r       <= 1'b0;
      end else begin
         wr_ptr_r        <= wr_ptr_nxt_s;
         rd_ptr_r        <= rd_ptr_nxt_s;
         out_valid_r     <= !empty_nxt_s;
         out_data_r      <= head_nxt_s;
         framing_error_r <= frame_err_s;
         overrun_r       <= overrun_s;
      end
   end

   assign out_valid     = out_valid_r;
   assign out_data      = out_data_r;
   assign framing_error = framing_error_r;
   assign overrun       = overrun_r;

endmodule

// File: doc/peridot_uart_rxd.md
# peridot_uart_rxd

Asynchronous serial receiver that forms the upstream byte source of the host bridge's configuration-layer stage. It synchronises the RXD pin, recovers 8N1 frames with mid-bit sampling, and buffers received bytes in a small show-ahead FIFO. The FIFO drives an Avalon-ST source (ready/valid, no backpressure on the line side). Framing errors and FIFO overruns are reported as single-cycle pulses.

## Interface
Parameters:
- CLOCK_FREQUENCY, default 50000000: clock_sig frequency in Hz.
- UART_BAUDRATE, default 115200: line bit rate in bps.
- FIFO_DEPTH_BITS, default 2: FIFO holds 2**FIFO_DEPTH_BITS bytes (range 1..6).
- Derived: BIT_CYCLES = CLOCK_FREQUENCY / UART_BAUDRATE (integer division, must be ≥ 4); HALF_CYCLES = BIT_CYCLES / 2.

Ports:
- clock_sig, in, 1: clock. All state is rising-edge driven.
- reset_sig, in, 1: reset. Asynchronous, active-high.
- rxd, in, 1: serial line input. Asynchronous to clock_sig; idle level is high.
- out_ready, in, 1: sink ready.
- out_valid, out, 1: FIFO not empty.
- out_data, out, 8: FIFO head byte (show-ahead).
- framing_error, out, 1: one-cycle pulse when the stop bit is sampled low.
- overrun, out, 1: one-cycle pulse when a completed byte is dropped because the FIFO is full.

## Operation
- Input synchroniser: 2 flip-flops followed by a previous-value register. All three reset to 1. The synchronised level is rx_s; a falling edge is rx_s==0 with prev==1.
- Bit timer: a down-counter of width clog2(BIT_CYCLES). An expiry is the cycle in which the counter equals 0.
- State machine:
  - IDLE: on a falling edge, load HALF_CYCLES-1 and go to START.
  - START: on expiry, sample rx_s. If the sample is 1 (glitch), return to IDLE. Otherwise load BIT_CYCLES-1, clear the bit index, and go to DATA.
  - DATA: on each expiry, shift rx_s into shift_reg MSB-side, so the byte is assembled LSB first, and reload BIT_CYCLES-1. After the 8th sample, go to STOP.
  - STOP: on expiry, sample rx_s.
    - Sample is 1: push shift_reg into the FIFO, or pulse overrun if the push is refused, then go to IDLE.
    - Sample is 0: pulse framing_error, discard the byte, and go to BREAK.
  - BREAK: wait for rx_s==1, then go to IDLE. A new start bit is only recognised from IDLE via a fresh falling edge.
- FIFO:
  - Write and read pointers are FIFO_DEPTH_BITS+1 bits wide. Empty is ptr equality. Full is MSBs differing with the remaining bits equal.
  - Pop when out_valid && out_ready.
  - Push is accepted when the FIFO is not full, or when a pop occurs in the same cycle (simultaneous push and pop at full keeps it full). If neither holds, the byte is dropped and overrun pulses.
  - Push and pop in the same cycle at empty: the push is accepted and no pop occurs, because out_valid was 0.
- out_data shows mem[rd_ptr] and must be stable while out_valid=1 and out_ready=0.
- Pointer wrap-around is natural modulo 2**(FIFO_DEPTH_BITS+1).

## Timing
- Reset values:
  - Outputs: out_valid=0, out_data=0x00, framing_error=0, overrun=0.
  - Internal: state IDLE, timer 0, shift_reg 0x00, pointers 0, memory contents don't care.
  - out_data must read 0x00 from a zeroed head register or masked output.
- Pin-to-edge latency: 2 cycles through the synchroniser.
- Sampling schedule, with cycle t being the cycle in which the falling edge is detected in IDLE:
  - Start bit sampled at t+HALF_CYCLES.
  - Data bit i (i = 0..7) sampled at t+HALF_CYCLES+(i+1)*BIT_CYCLES.
  - Stop bit sampled at t+HALF_CYCLES+9*BIT_CYCLES.
- The push occurs on the stop-sample edge. out_valid rises on the following cycle.
- framing_error and overrun assert for exactly the cycle after the stop sample.
- Back-to-back frames: the state returns to IDLE at the stop sample, about a half bit before the stop bit ends, so the next start edge is caught.
- Reset mid-frame: the partial byte is lost, the FIFO is emptied, and reception restarts on the next falling edge after reset deassertion. A line held low at release must produce no byte until it goes high then low.

## Test plan
Benches use CLOCK_FREQUENCY=1600 and UART_BAUDRATE=100, so BIT_CYCLES=16 and HALF_CYCLES=8.
- Single frame 0x3A with out_ready=1 -> exactly one out_valid beat with out_data=0x3A, out_valid high 1 cycle after the stop sample, no error pulses.
- Back-to-back 0x55, 0xAA, 0x3D with zero idle time -> three beats in order 0x55, 0xAA, 0x3D.
- rxd low for 5 cycles then high (glitch) -> state returns to IDLE at the start sample, no beat, no error pulses.
- Frame 0x12 with stop bit driven 0 for 2 bits then high -> framing_error pulses once, no beat; a following 0x34 is received correctly.
- out_ready=0 while sending 0x01..0x05 (depth 4) -> overrun pulses once on 0x05; after raising out_ready, beats 0x01..0x04 in order; plus one case of push and pop in the same cycle at full, where no overrun occurs.
- reset_sig asserted mid-DATA of 0x7E -> out_valid=0 and no stale byte; a subsequent 0xC3 is received correctly.
